// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-path definitions: ALU op codes, NZCV bit positions and
// the per-entry metadata stored alongside each buffered ALU result.
package legv8_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef struct packed {
    logic [3:0] nzcv;
    logic       illegal;
  } res_meta_t;

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// Purely combinational ALU: computes result, NZCV and an illegal-op flag.
// ORR is reserved and reported illegal until its datapath exists.
module alu_core
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        nzcv,
  output logic              illegal
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_eff;
  logic              is_sub;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    result  = '0;
    nzcv    = '0;
    illegal = 1'b0;
    is_sub  = (alu_op == ALU_SUB);
    b_eff   = is_sub ? ~op_b : op_b;
    sum     = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

    case (alu_op)
      ALU_AND:   result = op_a & op_b;
      ALU_ADD,
      ALU_SUB: begin
        result       = sum[DATA_W-1:0];
        nzcv[NZCV_C] = sum[DATA_W];
        nzcv[NZCV_V] = (op_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                       (sum[DATA_W-1] != op_a[DATA_W-1]);
      end
      ALU_PASSB: result = op_b;
      ALU_NOR:   result = ~(op_a | op_b);
      default:   illegal = 1'b1;
    endcase

    if (!illegal) begin
      nzcv[NZCV_N] = result[DATA_W-1];
      nzcv[NZCV_Z] = (result == '0);
    end
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU on accept, results buffered in a DEPTH-entry FIFO with
// valid/ready on both sides. EX_ALU_FLAGS_REG_EN adds the NZCV flags register.
module ex_alu_stage
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic              set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [3:0]        out_nzcv,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_illegal
`ifdef EX_ALU_FLAGS_REG_EN
  ,
  output logic [3:0]        flags_nzcv
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_nzcv;
  logic              alu_illegal;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .alu_op  (alu_op),
    .op_a    (op_a),
    .op_b    (op_b),
    .result  (alu_result),
    .nzcv    (alu_nzcv),
    .illegal (alu_illegal)
  );

  logic [DATA_W-1:0] result_mem [DEPTH];
  logic [TAG_W-1:0]  rd_mem     [DEPTH];
  res_meta_t         meta_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: storage is not reset; outputs are masked by out_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr] <= alu_result;
      rd_mem[wr_ptr]     <= in_rd;
      meta_mem[wr_ptr]   <= '{nzcv: alu_nzcv, illegal: alu_illegal};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_result  = out_valid ? result_mem[rd_ptr]         : '0;
  assign out_nzcv    = out_valid ? meta_mem[rd_ptr].nzcv      : '0;
  assign out_illegal = out_valid ? meta_mem[rd_ptr].illegal   : 1'b0;
  assign out_rd      = out_valid ? rd_mem[rd_ptr]             : '0;
  assign out_zero    = out_valid && (result_mem[rd_ptr] == '0);

`ifdef EX_ALU_FLAGS_REG_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_nzcv <= '0;
    end else if (push && set_flags && !alu_illegal) begin
      flags_nzcv <= alu_nzcv;
    end
  end
`else
  logic unused_set_flags;
  assign unused_set_flags = set_flags;
`endif

endmodule
